// File: rtl/mem_stage_pkg.sv
// mem_stage shared definitions: load funct3 codes,
// FSM states and memory unit size.
package mem_stage_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam int MemUnit = 4;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_RESP = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response bus.
// master = pipeline side, slave = memory side.
interface mem_stage_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  import mem_stage_pkg::*;

  logic               req;
  logic               we;
  logic [MemUnit-1:0] wem;
  logic [AW-1:0]      addr;
  logic [DW-1:0]      wdata;
  logic               gnt;
  logic               rvalid;
  logic [DW-1:0]      rdata;

  modport master (
    output req, we, wem, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, wem, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/gnrl_dfflr.sv
// Generic flop with load enable and
// asynchronous active-low reset to zero.
module gnrl_dfflr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lden,
  input  logic [W-1:0] dnxt,
  output logic [W-1:0] qout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/mem_ld_ext.sv
// Load data alignment: picks byte/halfword lane
// and sign- or zero-extends to DW.
module mem_ld_ext
  import mem_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] i_rdata,
  input  logic [1:0]    i_off,
  input  logic [2:0]    i_funct3,
  output logic [DW-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_rdata;
    unique case (1'b1)
      (i_funct3 == LB):
        o_data = {{(DW-8){w_byte[7]}}, w_byte};
      (i_funct3 == LBU):
        o_data = {{(DW-8){1'b0}}, w_byte};
      (i_funct3 == LH):
        o_data = {{(DW-16){w_half[15]}}, w_half};
      (i_funct3 == LHU):
        o_data = {{(DW-16){1'b0}}, w_half};
      default:
        o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores, holds
// the pipeline while outstanding, extends load data.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        instaddr_i,
  input  logic               cs_i,
  input  logic               mem_we_i,
  input  logic [MemUnit-1:0] mem_wem_i,
  input  logic [DW-1:0]      mem_din_i,
  input  logic [AW-1:0]      mem_addr_i,
  input  logic               regs_wen_i,
  input  logic [4:0]         rd_addr_i,
  input  logic [DW-1:0]      rd_data_i,
  mem_stage_if.master        dmem,
  output logic [31:0]        inst_o,
  output logic [31:0]        instaddr_o,
  output logic               regs_wen_o,
  output logic [4:0]         rd_addr_o,
  output logic [DW-1:0]      rd_data_o,
  output logic               stall_o,
  output logic               misalign_o
);

  mem_state_e  r_state;
  mem_state_e  w_nxt;
  logic [0:0]  w_state_q;
  logic [4:0]  r_ctx;
  logic        w_ctx_ld;
  logic [2:0]  w_funct3;
  logic        w_mis;
  logic [DW-1:0] w_ext;

  assign w_funct3 = inst_i[14:12];
  assign w_mis = cs_i & (
      ((w_funct3[1:0] == 2'b10) & (mem_addr_i[1:0] != 2'b00)) |
      ((w_funct3[1:0] == 2'b01) & mem_addr_i[0]));

  gnrl_dfflr #(.W(1)) u_state (
    .clk   (clk),
    .rst_n (rstn),
    .lden  (1'b1),
    .dnxt  (w_nxt),
    .qout  (w_state_q)
  );
  assign r_state = mem_state_e'(w_state_q);

  // RESP decodes from this snapshot, not the live inputs.
  gnrl_dfflr #(.W(5)) u_ctx (
    .clk   (clk),
    .rst_n (rstn),
    .lden  (w_ctx_ld),
    .dnxt  ({mem_addr_i[1:0], w_funct3}),
    .qout  (r_ctx)
  );

  mem_ld_ext #(.DW(DW)) u_ext (
    .i_rdata  (dmem.rdata),
    .i_off    (r_ctx[4:3]),
    .i_funct3 (r_ctx[2:0]),
    .o_data   (w_ext)
  );

  assign dmem.we    = mem_we_i;
  assign dmem.wem   = mem_wem_i;
  assign dmem.addr  = {mem_addr_i[AW-1:2], 2'b00};
  assign dmem.wdata = mem_din_i;

  assign inst_o     = inst_i;
  assign instaddr_o = instaddr_i;
  assign rd_addr_o  = rd_addr_i;

  always_comb begin
    w_nxt      = r_state;
    w_ctx_ld   = 1'b0;
    dmem.req   = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    regs_wen_o = regs_wen_i;
    rd_data_o  = rd_data_i;
    unique case (r_state)
      MEM_IDLE: begin
        if (cs_i) begin
          regs_wen_o = 1'b0;
          if (w_mis) begin
            misalign_o = 1'b1;
          end else begin
            dmem.req = 1'b1;
            if (!dmem.gnt) begin
              stall_o = 1'b1;
            end else if (!mem_we_i) begin
              stall_o  = 1'b1;
              w_ctx_ld = 1'b1;
              w_nxt    = MEM_RESP;
            end
          end
        end
      end
      MEM_RESP: begin
        stall_o    = ~dmem.rvalid;
        regs_wen_o = 1'b0;
        if (dmem.rvalid) begin
          rd_data_o  = w_ext;
          regs_wen_o = regs_wen_i;
          w_nxt      = MEM_IDLE;
        end
      end
      default: w_nxt = MEM_IDLE;
    endcase
  end

endmodule
